icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between the instruction fetcher and the memory controller. It returns hits one cycle after a request. On a miss it issues a single 4-byte fetch to the memory controller, fills the line, then answers the fetcher. A pipeline flush drops any pending answer without aborting the memory transaction.

---
 rtl/icache_if.sv | 33 +++
 rtl/icache.sv | 124 ++++++++++++
 tb/tb_icache.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetcher-side and memory-controller-side signals of the instruction cache.
// Define ICACHE_STAT_EN to add the hit/miss counters.
interface icache_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_ins;
  logic        flush;
  logic        mem_need;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_ins;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  modport master (
    output if_req, if_addr, flush, mem_ready, mem_ins,
`ifdef ICACHE_STAT_EN
    input  hit_cnt, miss_cnt,
`endif
    input  if_ready, if_ins, mem_need, mem_addr
  );

  modport slave (
    input  if_req, if_addr, flush, mem_ready, mem_ins,
`ifdef ICACHE_STAT_EN
    output hit_cnt, miss_cnt,
`endif
    output if_ready, if_ins, mem_need, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with single-word miss fills.
// Define ICACHE_STAT_EN to enable the hit/miss counters.
module icache #(
  parameter int unsigned IDX_WIDTH = 4
) (
  input logic     clk_in,
  input logic     rst_in,
  input logic     rdy_in,
  icache_if.slave bus
);
  localparam int unsigned Lines = 1 << IDX_WIDTH;
  localparam int unsigned TagW  = 30 - IDX_WIDTH;

  typedef enum logic [1:0] {StIdle, StMiss, StResp} state_e;

  state_e                 state_q;
  logic                   if_ready_q;
  logic [31:0]            if_ins_q;
  logic                   mem_need_q;
  logic [29:0]            pc_q;
  logic                   drop_q;
  logic [Lines-1:0]       valid_q;
  logic [TagW-1:0]        tag_q  [Lines];
  logic [31:0]            data_q [Lines];
`ifdef ICACHE_STAT_EN
  logic [31:0]            hit_cnt_q;
  logic [31:0]            miss_cnt_q;
`endif

  logic [IDX_WIDTH-1:0]   req_idx;
  logic [TagW-1:0]        req_tag;
  logic [IDX_WIDTH-1:0]   fill_idx;
  logic [TagW-1:0]        fill_tag;
  logic                   hit;
  logic                   fill_en;
  logic [1:0]             unused_addr;

  always_comb begin
    req_idx     = bus.if_addr[IDX_WIDTH+1:2];
    req_tag     = bus.if_addr[31:IDX_WIDTH+2];
    fill_idx    = pc_q[IDX_WIDTH-1:0];
    fill_tag    = pc_q[29:IDX_WIDTH];
    hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    fill_en     = rdy_in && (state_q == StMiss) && bus.mem_ready;
    unused_addr = bus.if_addr[1:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      if_ready_q <= 1'b0;
      if_ins_q   <= 32'h0;
      mem_need_q <= 1'b0;
      pc_q       <= 30'h0;
      drop_q     <= 1'b0;
      valid_q    <= '0;
`ifdef ICACHE_STAT_EN
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
`endif
    end else if (rdy_in) begin
      unique case (state_q)
        StIdle: begin
          if (bus.if_req && !bus.flush) begin
            if (hit) begin
              if_ins_q   <= data_q[req_idx];
              if_ready_q <= 1'b1;
              state_q    <= StResp;
`ifdef ICACHE_STAT_EN
              hit_cnt_q  <= hit_cnt_q + 32'd1;
`endif
            end else begin
              pc_q       <= bus.if_addr[31:2];
              mem_need_q <= 1'b1;
              drop_q     <= 1'b0;
              state_q    <= StMiss;
`ifdef ICACHE_STAT_EN
              miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
            end
          end
        end
        StMiss: begin
          if (bus.mem_ready) begin
            // The fill always lands; only the answer to the fetcher is dropped.
            mem_need_q        <= 1'b0;
            valid_q[fill_idx] <= 1'b1;
            if (!drop_q && !bus.flush) begin
              if_ins_q   <= bus.mem_ins;
              if_ready_q <= 1'b1;
              state_q    <= StResp;
            end else begin
              state_q    <= StIdle;
            end
          end else if (bus.flush) begin
            drop_q <= 1'b1;
          end
        end
        StResp: begin
          if_ready_q <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_ins;
    end
  end

  assign bus.if_ready = if_ready_q;
  assign bus.if_ins   = if_ins_q;
  assign bus.mem_need = mem_need_q;
  assign bus.mem_addr = {pc_q, 2'b00};
`ifdef ICACHE_STAT_EN
  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache; counter checks run when ICACHE_STAT_EN is defined.
module tb_icache;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;

  icache_if bus ();

  icache #(.IDX_WIDTH(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after the edge that accepted a missing request.
  task automatic serve_miss(input logic [31:0] a, input logic [31:0] d, input int delay);
    chk("miss_need", {31'h0, bus.mem_need}, 32'd1);
    chk("miss_addr", bus.mem_addr, a);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("miss_hold_need", {31'h0, bus.mem_need}, 32'd1);
      chk("miss_hold_addr", bus.mem_addr, a);
      chk("miss_no_ready", {31'h0, bus.if_ready}, 32'd0);
    end
    bus.mem_ready = 1'b1;
    bus.mem_ins   = d;
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_ins   = 32'h0;
    chk("fill_need_drop", {31'h0, bus.mem_need}, 32'd0);
    chk("fill_ready", {31'h0, bus.if_ready}, 32'd1);
    chk("fill_ins", bus.if_ins, d);
    bus.if_req = 1'b0;
    tick();
    chk("fill_ready_pulse", {31'h0, bus.if_ready}, 32'd0);
  endtask

  task automatic hit_once(input logic [31:0] a, input logic [31:0] d);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    tick();
    chk("hit_ready", {31'h0, bus.if_ready}, 32'd1);
    chk("hit_ins", bus.if_ins, d);
    chk("hit_no_need", {31'h0, bus.mem_need}, 32'd0);
    bus.if_req = 1'b0;
    tick();
    chk("hit_ready_pulse", {31'h0, bus.if_ready}, 32'd0);
  endtask

  initial begin
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_ins   = 32'h0;

    // Reset values
    #1 rst_in = 1'b1;
    #1;
    chk("rst_ready", {31'h0, bus.if_ready}, 32'd0);
    chk("rst_ins", bus.if_ins, 32'h0);
    chk("rst_need", {31'h0, bus.mem_need}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'h0);
`ifdef ICACHE_STAT_EN
    chk("rst_hit_cnt", bus.hit_cnt, 32'd0);
    chk("rst_miss_cnt", bus.miss_cnt, 32'd0);
`endif
    tick();
    tick();
    rst_in = 1'b0;
    tick();

    // Cold miss with 3-cycle memory delay
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    tick();
    serve_miss(32'h0000_0010, 32'h00A0_0093, 3);

    // Hit after fill (low address bits ignored)
    hit_once(32'h0000_0013, 32'h00A0_0093);
`ifdef ICACHE_STAT_EN
    chk("cnt_hit_1", bus.hit_cnt, 32'd1);
    chk("cnt_miss_1", bus.miss_cnt, 32'd1);
`endif

    // Conflict: 0x50 and 0x10 share index 4
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0050;
    tick();
    serve_miss(32'h0000_0050, 32'h0050_0113, 1);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    tick();
    serve_miss(32'h0000_0010, 32'h00A0_0093, 0);

    // Flush during miss
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0020;
    tick();
    chk("fl_need", {31'h0, bus.mem_need}, 32'd1);
    tick();
    tick();
    bus.flush  = 1'b1;
    bus.if_req = 1'b0;
    tick();
    bus.flush = 1'b0;
    chk("fl_need_held", {31'h0, bus.mem_need}, 32'd1);
    chk("fl_addr_held", bus.mem_addr, 32'h0000_0020);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_ins   = 32'h2222_2222;
    tick();
    bus.mem_ready = 1'b0;
    chk("fl_no_ready", {31'h0, bus.if_ready}, 32'd0);
    chk("fl_need_drop", {31'h0, bus.mem_need}, 32'd0);
    tick();
    chk("fl_still_no_ready", {31'h0, bus.if_ready}, 32'd0);
    hit_once(32'h0000_0020, 32'h2222_2222);

    // Flush in IDLE ignores the request
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0030;
    bus.flush   = 1'b1;
    tick();
    chk("idle_fl_need", {31'h0, bus.mem_need}, 32'd0);
    chk("idle_fl_ready", {31'h0, bus.if_ready}, 32'd0);
    bus.flush = 1'b0;

    // Flush coincident with mem_ready: fill without response
    tick();
    chk("fr_need", {31'h0, bus.mem_need}, 32'd1);
    chk("fr_addr", bus.mem_addr, 32'h0000_0030);
    bus.mem_ready = 1'b1;
    bus.mem_ins   = 32'h3333_3333;
    bus.flush     = 1'b1;
    bus.if_req    = 1'b0;
    tick();
    bus.mem_ready = 1'b0;
    bus.flush     = 1'b0;
    chk("fr_no_ready", {31'h0, bus.if_ready}, 32'd0);
    chk("fr_need_drop", {31'h0, bus.mem_need}, 32'd0);
    hit_once(32'h0000_0030, 32'h3333_3333);

    // Held request: one response every 2 cycles, no memory traffic
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_ready_hi", {31'h0, bus.if_ready}, 32'd1);
      chk("held_no_need", {31'h0, bus.mem_need}, 32'd0);
      tick();
      chk("held_ready_lo", {31'h0, bus.if_ready}, 32'd0);
    end
    bus.if_req = 1'b0;
    tick();

    // rdy_in low mid-miss: frozen, flush while frozen is not seen
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    tick();
    chk("rdy_need", {31'h0, bus.mem_need}, 32'd1);
    rdy_in    = 1'b0;
    bus.flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_frz_need", {31'h0, bus.mem_need}, 32'd1);
      chk("rdy_frz_addr", bus.mem_addr, 32'h0000_0040);
    end
    rdy_in    = 1'b1;
    bus.flush = 1'b0;
    tick();
    serve_miss(32'h0000_0040, 32'h0040_0193, 0);

    // rdy_in low stretches the if_ready pulse
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    tick();
    chk("str_ready", {31'h0, bus.if_ready}, 32'd1);
    rdy_in     = 1'b0;
    bus.if_req = 1'b0;
    tick();
    chk("str_ready_1", {31'h0, bus.if_ready}, 32'd1);
    tick();
    chk("str_ready_2", {31'h0, bus.if_ready}, 32'd1);
    rdy_in = 1'b1;
    tick();
    chk("str_ready_end", {31'h0, bus.if_ready}, 32'd0);

    // Reset asserted mid-miss after a frozen stretch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0044;
    tick();
    chk("rm_need", {31'h0, bus.mem_need}, 32'd1);
    chk("rm_addr", bus.mem_addr, 32'h0000_0044);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rm_frz_need", {31'h0, bus.mem_need}, 32'd1);
    end
    rdy_in = 1'b1;
`ifdef ICACHE_STAT_EN
    chk("cnt_hit_pre_rst", bus.hit_cnt, 32'd7);
    chk("cnt_miss_pre_rst", bus.miss_cnt, 32'd7);
`endif
    #1 rst_in = 1'b1;
    #1;
    chk("rm_rst_need", {31'h0, bus.mem_need}, 32'd0);
    chk("rm_rst_addr", bus.mem_addr, 32'h0);
    chk("rm_rst_ready", {31'h0, bus.if_ready}, 32'd0);
`ifdef ICACHE_STAT_EN
    chk("rm_rst_hit_cnt", bus.hit_cnt, 32'd0);
`endif
    bus.if_req = 1'b0;
    tick();
    rst_in = 1'b0;
    tick();

    // Previously valid line must miss after reset
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    tick();
    chk("post_rst_ready", {31'h0, bus.if_ready}, 32'd0);
    serve_miss(32'h0000_0040, 32'h0040_0193, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
